// File: rtl/wb_streamer_pkg.sv
// rtl/wb_streamer_pkg.sv - register map, bit indices and default base address for wb_sample_streamer
package wb_streamer_pkg;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h3000_0000;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_DIV    = 2'd1;
  localparam logic [1:0] REG_DATA   = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_LOOP   = 1;
  localparam int CTRL_FLUSH  = 2;
  localparam int CTRL_IRQ_EN = 3;

  localparam int ST_EMPTY = 8;
  localparam int ST_FULL  = 9;
  localparam int ST_UNDER = 10;
  localparam int ST_OVER  = 11;

endpackage

// File: rtl/wb_sample_streamer_if.sv
// rtl/wb_sample_streamer_if.sv - Wishbone slave bus plus sample stream and irq of the streamer
interface wb_sample_streamer_if #(
  parameter int DATA_W = 8
);
  logic              wbs_cyc_i;
  logic              wbs_stb_i;
  logic              wbs_we_i;
  logic [3:0]        wbs_sel_i;
  logic [31:0]       wbs_adr_i;
  logic [31:0]       wbs_dat_i;
  logic              wbs_ack_o;
  logic [31:0]       wbs_dat_o;
  logic [DATA_W-1:0] sample_o;
  logic              sample_valid_o;
  logic              sample_ready_i;
  logic              irq_o;

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i, sample_ready_i,
    output wbs_ack_o, wbs_dat_o, sample_o, sample_valid_o, irq_o
  );

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i, sample_ready_i,
    input  wbs_ack_o, wbs_dat_o, sample_o, sample_valid_o, irq_o
  );
endinterface

// File: rtl/wb_sample_streamer_fifo.sv
// rtl/wb_sample_streamer_fifo.sv - sample_fifo: synchronous FIFO with flush and loop re-push of the popped head
module sample_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  input  logic              loop_i,
  output logic [DATA_W-1:0] head_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              full_o,
  output logic              empty_o,
  output logic              overflow_o
);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  rd_q, rd_d, wr_q, wr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              we;
  logic [DATA_W-1:0] wdata;
  logic              repush, push_ok;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_q];
  assign count_o = count_q;

  // The single write port belongs to the loop re-push; a colliding DATA push is dropped.
  assign repush     = pop_i & loop_i;
  assign push_ok    = push_i & ~repush & (~full_o | pop_i);
  assign overflow_o = push_i & ~flush_i & ~push_ok;

  always_comb begin
    rd_d    = rd_q;
    wr_d    = wr_q;
    count_d = count_q;
    we      = 1'b0;
    wdata   = push_data_i;
    if (flush_i) begin
      rd_d    = '0;
      wr_d    = '0;
      count_d = '0;
    end else if (repush) begin
      we    = 1'b1;
      wdata = head_o;
      rd_d  = rd_q + 1'b1;
      wr_d  = wr_q + 1'b1;
    end else begin
      if (push_ok) begin
        we   = 1'b1;
        wr_d = wr_q + 1'b1;
      end
      if (pop_i) rd_d = rd_q + 1'b1;
      if (push_ok && !pop_i)      count_d = count_q + 1'b1;
      else if (!push_ok && pop_i) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (we) mem_q[wr_q] <= wdata;
  end
endmodule

// File: rtl/wb_sample_streamer.sv
// rtl/wb_sample_streamer.sv - Wishbone-fed sample FIFO with rate-divided valid/ready playback
module wb_sample_streamer
  import wb_streamer_pkg::*;
#(
  parameter int          DATA_W    = 8,
  parameter int          DEPTH     = 16,
  parameter int          DIV_W     = 16,
  parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR
) (
  input logic                  wb_clk_i,
  input logic                  wb_rst_i,
  wb_sample_streamer_if.slave  bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              ack_q, ack_d;
  logic              en_q, en_d, loop_q, loop_d, irq_en_q, irq_en_d;
  logic [DIV_W-1:0]  div_q, div_d, cnt_q, cnt_d;
  logic              under_q, under_d, over_q, over_d, irq_q, irq_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] sample_q, sample_d;

  logic              hit, wr_en, flush, push, tick, load;
  logic [1:0]        reg_sel;
  logic [DATA_W-1:0] fifo_head;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full, fifo_empty, fifo_overflow;
  logic [31:0]       status_word, rdata;
  logic              unused_bits;

  assign hit     = (bus.wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign reg_sel = bus.wbs_adr_i[3:2];
  assign wr_en   = ack_q & bus.wbs_cyc_i & bus.wbs_stb_i & bus.wbs_we_i & bus.wbs_sel_i[0];
  assign flush   = wr_en & (reg_sel == REG_CTRL) & bus.wbs_dat_i[CTRL_FLUSH];
  assign push    = wr_en & (reg_sel == REG_DATA);
  assign tick    = en_q & (cnt_q == div_q);
  // A tick while the output is stalled is simply dropped.
  assign load    = tick & ~fifo_empty & (~valid_q | bus.sample_ready_i);

  assign unused_bits = ^{bus.wbs_sel_i[3:1], bus.wbs_adr_i[1:0], bus.wbs_dat_i};

  sample_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk_i       (wb_clk_i),
    .rst_i       (wb_rst_i),
    .flush_i     (flush),
    .push_i      (push),
    .push_data_i (bus.wbs_dat_i[DATA_W-1:0]),
    .pop_i       (load),
    .loop_i      (loop_q),
    .head_o      (fifo_head),
    .count_o     (fifo_count),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .overflow_o  (fifo_overflow)
  );

  always_comb begin
    status_word           = '0;
    status_word[7:0]      = 8'(fifo_count);
    status_word[ST_EMPTY] = fifo_empty;
    status_word[ST_FULL]  = fifo_full;
    status_word[ST_UNDER] = under_q;
    status_word[ST_OVER]  = over_q;
    rdata = '0;
    if (ack_q) begin
      case (reg_sel)
        REG_CTRL:   rdata = {28'd0, irq_en_q, 1'b0, loop_q, en_q};
        REG_DIV:    rdata = 32'(div_q);
        REG_STATUS: rdata = status_word;
        default:    rdata = '0;
      endcase
    end
  end

  always_comb begin
    ack_d    = bus.wbs_cyc_i & bus.wbs_stb_i & hit & ~ack_q;
    en_d     = en_q;
    loop_d   = loop_q;
    irq_en_d = irq_en_q;
    div_d    = div_q;
    under_d  = under_q;
    over_d   = over_q;
    valid_d  = valid_q;
    sample_d = sample_q;
    cnt_d    = '0;
    if (en_q && !tick) cnt_d = cnt_q + 1'b1;
    if (wr_en && reg_sel == REG_CTRL) begin
      en_d     = bus.wbs_dat_i[CTRL_EN];
      loop_d   = bus.wbs_dat_i[CTRL_LOOP];
      irq_en_d = bus.wbs_dat_i[CTRL_IRQ_EN];
    end
    if (wr_en && reg_sel == REG_DIV) div_d = bus.wbs_dat_i[DIV_W-1:0];
    if (wr_en && reg_sel == REG_STATUS) begin
      if (bus.wbs_dat_i[ST_UNDER]) under_d = 1'b0;
      if (bus.wbs_dat_i[ST_OVER])  over_d  = 1'b0;
    end
    // New events win over a same-cycle clear so none is lost.
    if (tick && fifo_empty) under_d = 1'b1;
    if (fifo_overflow)      over_d  = 1'b1;
    irq_d = irq_en_q & (under_q | over_q);
    if (flush) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d  = 1'b1;
      sample_d = fifo_head;
    end else if (valid_q && bus.sample_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_q    <= 1'b0;
      en_q     <= 1'b0;
      loop_q   <= 1'b0;
      irq_en_q <= 1'b0;
      div_q    <= '0;
      cnt_q    <= '0;
      under_q  <= 1'b0;
      over_q   <= 1'b0;
      irq_q    <= 1'b0;
      valid_q  <= 1'b0;
      sample_q <= '0;
    end else begin
      ack_q    <= ack_d;
      en_q     <= en_d;
      loop_q   <= loop_d;
      irq_en_q <= irq_en_d;
      div_q    <= div_d;
      cnt_q    <= cnt_d;
      under_q  <= under_d;
      over_q   <= over_d;
      irq_q    <= irq_d;
      valid_q  <= valid_d;
      sample_q <= sample_d;
    end
  end

  assign bus.wbs_ack_o      = ack_q;
  assign bus.wbs_dat_o      = rdata;
  assign bus.sample_o       = sample_q;
  assign bus.sample_valid_o = valid_q;
  assign bus.irq_o          = irq_q;
endmodule

// File: tb/tb_wb_sample_streamer.sv
// tb/tb_wb_sample_streamer.sv - directed bench for wb_sample_streamer with a queue-based reference model
module tb_wb_sample_streamer;
  localparam int          DATA_W = 8;
  localparam int          DEPTH  = 16;
  localparam int          DIV_W  = 16;
  localparam logic [31:0] BASE   = 32'h3000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_sample_streamer_if #(.DATA_W(DATA_W)) bus ();

  wb_sample_streamer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .DIV_W(DIV_W), .BASE_ADDR(BASE)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO as a queue, registers and flags as plain variables.
  logic [DATA_W-1:0] m_q[$];
  bit                m_ack, m_en, m_loop, m_irq_en, m_under, m_over, m_irq, m_valid;
  int unsigned       m_div, m_cnt;
  logic [DATA_W-1:0] m_sample;
  int                cycle = 0;
  logic [DATA_W-1:0] cap_v[$];
  int                cap_c[$];

  function automatic logic [31:0] m_rdata(input logic [1:0] rs);
    case (rs)
      2'd0:    return {28'd0, m_irq_en, 1'b0, m_loop, m_en};
      2'd1:    return m_div;
      2'd2:    return 32'd0;
      default: return {20'd0, m_over, m_under, m_q.size() == DEPTH, m_q.size() == 0, 8'(m_q.size())};
    endcase
  endfunction

  always @(posedge clk) begin
    bit                hit, wr, tick, pop, flush;
    logic [1:0]        rs;
    logic [DATA_W-1:0] h;
    cycle++;
    if (rst) begin
      m_q.delete();
      {m_ack, m_en, m_loop, m_irq_en, m_under, m_over, m_irq, m_valid} = '0;
      m_div = 0; m_cnt = 0; m_sample = '0;
    end else begin
      hit   = (bus.wbs_adr_i >> 4) == (BASE >> 4);
      rs    = bus.wbs_adr_i[3:2];
      wr    = m_ack && bus.wbs_cyc_i && bus.wbs_stb_i && bus.wbs_we_i && bus.wbs_sel_i[0];
      flush = wr && rs == 2'd0 && bus.wbs_dat_i[2];
      tick  = m_en && m_cnt == m_div;
      pop   = tick && m_q.size() > 0 && (!m_valid || bus.sample_ready_i);
      m_irq = m_irq_en && (m_under || m_over);
      if (wr && rs == 2'd3) begin
        if (bus.wbs_dat_i[10]) m_under = 1'b0;
        if (bus.wbs_dat_i[11]) m_over  = 1'b0;
      end
      if (tick && m_q.size() == 0) m_under = 1'b1;
      if (flush) begin
        m_q.delete();
        m_valid = 1'b0;
      end else begin
        if (pop) begin
          h = m_q.pop_front();
          m_sample = h;
          m_valid  = 1'b1;
          if (m_loop) m_q.push_back(h);
        end else if (m_valid && bus.sample_ready_i) begin
          m_valid = 1'b0;
        end
        if (wr && rs == 2'd2) begin
          if ((pop && m_loop) || m_q.size() >= DEPTH) m_over = 1'b1;
          else m_q.push_back(bus.wbs_dat_i[DATA_W-1:0]);
        end
      end
      if (!m_en || tick) m_cnt = 0;
      else m_cnt++;
      if (wr && rs == 2'd0) begin
        m_en     = bus.wbs_dat_i[0];
        m_loop   = bus.wbs_dat_i[1];
        m_irq_en = bus.wbs_dat_i[3];
      end
      if (wr && rs == 2'd1) m_div = bus.wbs_dat_i[DIV_W-1:0];
      m_ack = bus.wbs_cyc_i && bus.wbs_stb_i && hit && !m_ack;
    end
  end

  always @(negedge clk) begin
    check("ack", bus.wbs_ack_o, m_ack);
    check("dat_o", bus.wbs_dat_o, m_ack ? m_rdata(bus.wbs_adr_i[3:2]) : 32'd0);
    check("valid", bus.sample_valid_o, m_valid);
    check("sample", bus.sample_o, m_sample);
    check("irq", bus.irq_o, m_irq);
    if (bus.sample_valid_o && bus.sample_ready_i) begin
      cap_v.push_back(bus.sample_o);
      cap_c.push_back(cycle);
    end
  end

  task automatic bus_idle();
    bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
    bus.wbs_sel_i = 4'h0; bus.wbs_adr_i = 32'd0; bus.wbs_dat_i = 32'd0;
  endtask

  task automatic wb_cycle(input logic [31:0] a, input logic we, input logic [31:0] d,
                          output logic [31:0] rd);
    bit got;
    got = 1'b0;
    rd  = 32'd0;
    @(posedge clk); #1;
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = we;
    bus.wbs_sel_i = 4'hf; bus.wbs_adr_i = a; bus.wbs_dat_i = d;
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge clk); #1;
      if (bus.wbs_ack_o) begin
        got = 1'b1;
        rd  = bus.wbs_dat_o;
      end
    end
    @(posedge clk); #1;
    bus_idle();
    check("ack_seen", got, 1'b1);
  endtask

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] unused_rd;
    wb_cycle(a, 1'b1, d, unused_rd);
  endtask

  task automatic wb_read(input logic [31:0] a, output logic [31:0] rd);
    wb_cycle(a, 1'b0, 32'd0, rd);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] rd;
    bit          seen;
    bus_idle();
    bus.sample_ready_i = 1'b1;
    rst = 1'b1;
    wait_cycles(3);
    rst = 1'b0;
    check("rst_valid", bus.sample_valid_o, 1'b0);
    check("rst_sample", bus.sample_o, 8'h00);
    wb_read(BASE + 32'hC, rd); check("rst_status", rd, 32'h100);
    wb_read(BASE + 32'h0, rd); check("rst_ctrl", rd, 32'h0);

    // One-shot playback, DIV=3.
    wb_write(BASE + 32'h4, 32'd3);
    wb_write(BASE + 32'h8, 32'h11);
    wb_write(BASE + 32'h8, 32'h22);
    wb_write(BASE + 32'h8, 32'h33);
    cap_v.delete(); cap_c.delete();
    wb_write(BASE + 32'h0, 32'h1);
    wait_cycles(24);
    check("t1_count", cap_v.size(), 3);
    if (cap_v.size() >= 3) begin
      check("t1_s0", cap_v[0], 8'h11);
      check("t1_s1", cap_v[1], 8'h22);
      check("t1_s2", cap_v[2], 8'h33);
      check("t1_gap01", cap_c[1] - cap_c[0], 4);
      check("t1_gap12", cap_c[2] - cap_c[1], 4);
    end
    wb_read(BASE + 32'hC, rd); check("t1_status", rd, 32'h500);
    wb_write(BASE + 32'h0, 32'h0);
    wb_write(BASE + 32'hC, 32'h400);
    wb_read(BASE + 32'hC, rd); check("t1_w1c", rd, 32'h100);

    // Circular playback, DIV=0.
    wb_write(BASE + 32'h8, 32'hA0);
    wb_write(BASE + 32'h8, 32'hA5);
    wb_write(BASE + 32'h4, 32'd0);
    cap_v.delete(); cap_c.delete();
    wb_write(BASE + 32'h0, 32'h3);
    wait_cycles(12);
    check("t2_enough", cap_v.size() >= 8, 1'b1);
    for (int i = 0; i < 8 && i < cap_v.size(); i++)
      check("t2_alt", cap_v[i], (i % 2) ? 8'hA5 : 8'hA0);
    wb_read(BASE + 32'hC, rd); check("t2_status", rd, 32'h002);
    wb_write(BASE + 32'h0, 32'h4);

    // Overflow, then irq enable and W1C.
    for (int i = 0; i < 17; i++) wb_write(BASE + 32'h8, 32'(i + 1));
    wb_read(BASE + 32'hC, rd); check("t3_status", rd, 32'hA10);
    wb_write(BASE + 32'h0, 32'h8);
    wait_cycles(1);
    check("t3_irq_on", bus.irq_o, 1'b1);
    wb_write(BASE + 32'hC, 32'h800);
    wait_cycles(1);
    check("t3_irq_off", bus.irq_o, 1'b0);
    wb_read(BASE + 32'hC, rd); check("t3_cleared", rd, 32'h210);

    // Output stall with two samples queued.
    wb_write(BASE + 32'h0, 32'h4);
    wb_write(BASE + 32'h8, 32'h5A);
    wb_write(BASE + 32'h8, 32'h6B);
    bus.sample_ready_i = 1'b0;
    cap_v.delete(); cap_c.delete();
    wb_write(BASE + 32'h0, 32'h1);
    wait_cycles(6);
    check("t4_held_valid", bus.sample_valid_o, 1'b1);
    check("t4_held_data", bus.sample_o, 8'h5A);
    wb_read(BASE + 32'hC, rd); check("t4_count1", rd, 32'h001);
    bus.sample_ready_i = 1'b1;
    wait_cycles(1);
    check("t4_next", bus.sample_o, 8'h6B);
    wait_cycles(3);
    check("t4_caps", cap_v.size(), 2);
    if (cap_v.size() >= 2) begin
      check("t4_cap0", cap_v[0], 8'h5A);
      check("t4_cap1", cap_v[1], 8'h6B);
    end

    // Flush while streaming; sticky underrun survives.
    wb_write(BASE + 32'h0, 32'h0);
    for (int i = 0; i < 4; i++) wb_write(BASE + 32'h8, 32'(8'hC0 + i));
    wb_write(BASE + 32'h4, 32'd3);
    bus.sample_ready_i = 1'b0;
    wb_write(BASE + 32'h0, 32'h1);
    wait_cycles(6);
    check("t5_pre_valid", bus.sample_valid_o, 1'b1);
    wb_write(BASE + 32'h0, 32'h5);
    check("t5_valid_off", bus.sample_valid_o, 1'b0);
    wb_read(BASE + 32'hC, rd); check("t5_status", rd, 32'h500);
    bus.sample_ready_i = 1'b1;
    wb_write(BASE + 32'h0, 32'h0);

    // Address miss gets no ack.
    @(posedge clk); #1;
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_adr_i = BASE + 32'h10;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (bus.wbs_ack_o) seen = 1'b1;
    end
    check("t6_miss_noack", seen, 1'b0);
    bus_idle();

    // Reset in the middle of an access.
    @(posedge clk); #1;
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_adr_i = BASE + 32'hC;
    rst = 1'b1;
    wait_cycles(1);
    check("t6_rst_ack", bus.wbs_ack_o, 1'b0);
    wait_cycles(1);
    check("t6_rst_ack2", bus.wbs_ack_o, 1'b0);
    check("t6_rst_dat", bus.wbs_dat_o, 32'h0);
    check("t6_rst_valid", bus.sample_valid_o, 1'b0);
    check("t6_rst_sample", bus.sample_o, 8'h00);
    check("t6_rst_irq", bus.irq_o, 1'b0);
    bus_idle();
    rst = 1'b0;
    wb_read(BASE + 32'hC, rd); check("t6_status", rd, 32'h100);
    wb_read(BASE + 32'h4, rd); check("t6_div", rd, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete within the time limit");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/wb_sample_streamer.md
Name: wb_sample_streamer

Overview:
Wishbone-slave sample buffer that sits directly upstream of signal_generator in the user analog wrapper.
- Management SoC writes DAC sample codes into a FIFO over Wishbone.
- A programmable rate divider pops samples at a fixed cadence and presents them on a valid/ready stream consumed by signal_generator.
- Supports one-shot and circular (loop) playback; flags underrun/overflow via a sticky status register and an interrupt.

Parameters:
DATA_W, 8, sample code width
DEPTH, 16, FIFO entries (power of two, >=2)
DIV_W, 16, rate divider width
BASE_ADDR, 32'h3000_0000, register window base (16-byte window)

Ports:
wb_clk_i  in  1  single clock
wb_rst_i  in  1  synchronous active-high reset
wbs_cyc_i  in  1  Wishbone cycle
wbs_stb_i  in  1  Wishbone strobe
wbs_we_i  in  1  write enable
wbs_sel_i  in  4  byte selects (byte 0 required for writes to take effect)
wbs_adr_i  in  32  byte address
wbs_dat_i  in  32  write data
wbs_ack_o  out  1  acknowledge
wbs_dat_o  out  32  read data
sample_o  out  DATA_W  sample to signal_generator
sample_valid_o  out  1  sample_o valid
sample_ready_i  in  1  consumer accepts sample
irq_o  out  1  interrupt (level)

Behaviour:
- Reset (sync, wb_rst_i=1 at clock edge): all outputs 0; FIFO empty; CTRL=0; DIV=0; sticky flags 0; divider counter 0.
- Address decode: hit when wbs_adr_i[31:4]==BASE_ADDR[31:4]; register select = wbs_adr_i[3:2]. A miss produces no ack.
- Wishbone timing:
  - On cyc&stb&hit with ack low, ack=1 on the next cycle for exactly one cycle; no back-to-back acks.
  - Write side effects take place in the ack cycle.
  - wbs_dat_o is valid while ack=1, else 0.
- Registers:
  - 0x0 CTRL rw: [0] enable, [1] loop, [2] flush (write-1, self-clearing, reads 0), [3] irq_en.
  - 0x4 DIV rw: [DIV_W-1:0] tick period minus one.
  - 0x8 DATA wo: write pushes wbs_dat_i[DATA_W-1:0]; reads return 0.
  - 0xC STATUS: [7:0] count ro, [8] empty ro, [9] full ro, [10] underrun W1C, [11] overflow W1C.
- Divider and tick:
  - While enable=1, the counter increments each cycle; tick when counter==DIV, then counter returns to 0.
  - DIV=0 gives a tick every cycle.
  - enable=0 holds the counter at 0 and produces no ticks.
- Pop rule: on tick, if FIFO non-empty and (!sample_valid_o || sample_ready_i), the head loads into sample_o and sample_valid_o=1 next cycle.
- Handshake: sample_valid_o&&sample_ready_i without a concurrent load clears sample_valid_o. sample_o is held stable while valid&&!ready.
- Tick with FIFO empty: underrun sticky set; sample_valid_o unchanged by the tick.
- Tick while output stalled (valid&&!ready): no pop, no flag; the tick is lost, not queued.
- Loop mode: a popped entry is re-pushed to the tail in the same cycle, so count is unchanged and playback is circular.
- DATA push when full: data dropped, overflow sticky set. In loop mode the re-push has priority over a DATA push.
- Simultaneous push and non-loop pop: count unchanged; legal even when full (slot freed).
- Flush: pointers and count to 0; sample_valid_o=0 next cycle; sticky flags preserved. Flush overrides a same-cycle pop or push.
- irq_o = irq_en & (underrun | overflow), registered (1-cycle latency).
- Reset mid-transfer: ack suppressed; all state returns to reset values.

Decomposition:
- Shared package wb_streamer_pkg:
  - register offset constants (CTRL/DIV/DATA/STATUS)
  - CTRL and STATUS bit-index constants
  - default BASE_ADDR
- One natural sub-module: sample_fifo, a synchronous FIFO with push/pop, count, full/empty and a loop re-push port.
- Wishbone decode, divider and output stage stay in the top level.

Test Plan:
- DIV=3, enable=1, push 0x11, 0x22, 0x33 with ready held 1 → sample_o shows 0x11, 0x22, 0x33 on ticks 4 cycles apart; afterwards STATUS underrun=1.
- Loop=1, push 0xA0, 0xA5, DIV=0, ready=1 → sample_o alternates A0, A5 indefinitely; count stays 2; underrun stays 0.
- Push 17 samples with enable=0 (DEPTH=16) → STATUS count=16, full=1, overflow=1; irq_o=1 one cycle after irq_en is written 1; W1C to bit 11 clears overflow and drops irq_o.
- Hold ready=0 with DIV=0 and 2 samples queued → first sample held stable with valid=1, count stays 1; on ready=1 the second sample appears on the next tick.
- Write flush while streaming → sample_valid_o=0 and count=0 next cycle; sticky flags unchanged.
- Address miss (BASE_ADDR+0x10) → no ack; assert wb_rst_i mid-access → ack stays 0 and all outputs read 0.
